// File: rtl/stream_upsizer.sv
// Packs RATIO narrow FWFT tokens into one wide token with keep mask and end-of-transaction marker.
// A partial word is flushed on EoT and is always followed by a standalone EoT word.
module stream_upsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 4,
    parameter int CNT_WIDTH = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_empty_n,
    output logic                                in_read,
    input  logic [IN_WIDTH:0]                   in_dout,
    input  logic                                out_full_n,
    output logic                                out_write,
    output logic [1+RATIO+IN_WIDTH*RATIO-1:0]   out_din
);

    localparam int LANES_W = IN_WIDTH * RATIO;
    localparam int OUT_W   = 1 + RATIO + LANES_W;
    localparam logic [OUT_W-1:0] EOT_WORD = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(RATIO - 1);

    typedef enum logic {
        FILL,
        EOT_PEND
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [LANES_W-1:0]     lanes;
    logic [LANES_W-1:0]     lanes_next;
    logic [RATIO-1:0]       partial_keep;
    logic                   can_load;
    logic                   acc;
    logic                   tok_eot;

    // Valid/ready: out_write/out_din are held until out_full_n is seen high at a clock edge
    // (a transfer); upstream is popped only in a cycle where in_read and in_empty_n are both high.
    assign can_load = !out_write || out_full_n;
    assign in_read  = !reset && in_empty_n && (state == FILL) && can_load;
    assign acc      = in_read && in_empty_n;
    assign tok_eot  = in_dout[IN_WIDTH];

    always_comb begin
        lanes_next = lanes;
        lanes_next[int'(cnt)*IN_WIDTH +: IN_WIDTH] = in_dout[IN_WIDTH-1:0];
    end

    // Lanes below the current count are the ones already filled.
    always_comb begin
        partial_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            partial_keep[k] = (k < int'(cnt));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            cnt       <= '0;
            lanes     <= '0;
            out_write <= 1'b0;
            out_din   <= '0;
        end else begin
            if (out_write && out_full_n) begin
                out_write <= 1'b0;
            end
            case (state)
                FILL: begin
                    if (acc) begin
                        if (!tok_eot) begin
                            if (cnt == LAST_LANE) begin
                                out_din   <= {1'b0, {RATIO{1'b1}}, lanes_next};
                                out_write <= 1'b1;
                                cnt       <= '0;
                                lanes     <= '0;
                            end else begin
                                lanes <= lanes_next;
                                cnt   <= cnt + CNT_WIDTH'(1);
                            end
                        end else if (cnt != '0) begin
                            out_din   <= {1'b0, partial_keep, lanes};
                            out_write <= 1'b1;
                            cnt       <= '0;
                            lanes     <= '0;
                            state     <= EOT_PEND;
                        end else begin
                            out_din   <= EOT_WORD;
                            out_write <= 1'b1;
                        end
                    end
                end
                EOT_PEND: begin
                    if (can_load) begin
                        out_din   <= EOT_WORD;
                        out_write <= 1'b1;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// Scoreboard bench for stream_upsizer: FWFT upstream driver, FIFO-style downstream sink.
module tb_stream_upsizer;
  localparam int IW = 32;
  localparam int R  = 4;
  localparam int CW = 2;
  localparam int OW = 1 + R + IW * R;

  logic clk = 1'b0;
  logic reset;
  logic in_empty_n;
  logic in_read;
  logic [IW:0] in_dout;
  logic out_full_n;
  logic out_write;
  logic [OW-1:0] out_din;

  int checks = 0;
  int errors = 0;

  logic [IW:0] tok_q[$];
  logic [OW-1:0] exp_q[$];

  bit up_rand = 0;
  bit dn_rand = 0;
  bit dn_hold = 0;

  logic acc_s = 1'b0;
  logic xfer_s = 1'b0;
  logic [OW-1:0] dout_s = '0;
  int acc_cnt = 0;
  int xfer_cnt = 0;

  int m_cnt = 0;
  logic [IW*R-1:0] m_lanes = '0;

  // clock / reset
  always #5 clk = ~clk;

  stream_upsizer #(.IN_WIDTH(IW), .RATIO(R), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset(reset),
    .in_empty_n(in_empty_n),
    .in_read(in_read),
    .in_dout(in_dout),
    .out_full_n(out_full_n),
    .out_write(out_write),
    .out_din(out_din)
  );

  // handshake capture at the active edge
  always @(posedge clk) begin
    acc_s  <= in_read & in_empty_n;
    xfer_s <= out_write & out_full_n;
    dout_s <= out_din;
  end

  // upstream FWFT source and downstream sink
  always @(negedge clk) begin
    if (acc_s === 1'b1 && tok_q.size() > 0) begin
      acc_cnt++;
      void'(tok_q.pop_front());
    end
    if (tok_q.size() > 0 && !(up_rand && $urandom_range(0, 3) == 0)) begin
      in_empty_n = 1'b1;
      in_dout = tok_q[0];
    end else begin
      in_empty_n = 1'b0;
      in_dout = {1'b0, $urandom};
    end
    out_full_n = dn_hold ? 1'b0 : (dn_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  // monitor: compare each transferred word against the expected queue
  always @(negedge clk) begin
    if (xfer_s === 1'b1) begin
      xfer_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected act=%h exp=<none>", dout_s);
      end else begin
        logic [OW-1:0] e;
        e = exp_q.pop_front();
        if (dout_s !== e) begin
          errors++;
          $display("FAIL word act=%h exp=%h", dout_s, e);
        end
      end
    end
  end

  task automatic check(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push_tok(bit eot, logic [IW-1:0] p);
    tok_q.push_back({eot, p});
  endtask

  // reference packing model used for bulk stimulus
  task automatic send(bit eot, logic [IW-1:0] p);
    tok_q.push_back({eot, p});
    if (!eot) begin
      m_lanes[m_cnt*IW +: IW] = p;
      if (m_cnt == R - 1) begin
        exp_q.push_back({1'b0, {R{1'b1}}, m_lanes});
        m_cnt = 0;
        m_lanes = '0;
      end else begin
        m_cnt++;
      end
    end else begin
      if (m_cnt > 0) begin
        exp_q.push_back({1'b0, R'((1 << m_cnt) - 1), m_lanes});
        m_cnt = 0;
        m_lanes = '0;
      end
      exp_q.push_back({1'b1, {(OW-1){1'b0}}});
    end
  endtask

  task automatic wait_acc(int target, string name);
    for (int n = 0; n < 200 && acc_cnt < target; n++) begin
      @(negedge clk); #1;
    end
    check(name, OW'(acc_cnt >= target), OW'(1));
  endtask

  task automatic wait_idle(int budget, string name);
    for (int n = 0; n < budget && (tok_q.size() > 0 || exp_q.size() > 0); n++) begin
      @(negedge clk); #1;
    end
    check(name, OW'(tok_q.size() + exp_q.size()), OW'(0));
    repeat (3) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    int base;
    int good;
    logic [OW-1:0] held;

    reset = 1'b1;
    in_empty_n = 1'b0;
    in_dout = '0;
    out_full_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_write", OW'(out_write), OW'(0));
    check("reset_out_din", out_din, '0);
    reset = 1'b0;

    // async reset mid-word with a token pending upstream
    push_tok(0, 32'hA1); push_tok(0, 32'hA2); push_tok(0, 32'hA3);
    @(negedge clk); @(negedge clk); @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_in_empty_n_seen", OW'(in_empty_n), OW'(1));
    check("async_reset_in_read", OW'(in_read), OW'(0));
    check("async_reset_out_write", OW'(out_write), OW'(0));
    @(negedge clk); @(negedge clk);
    tok_q.delete();
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;

    // full word 1..4, out_write one cycle after token 4
    base = acc_cnt;
    push_tok(0, 1); push_tok(0, 2); push_tok(0, 3); push_tok(0, 4);
    exp_q.push_back({1'b0, 4'hF, 32'h4, 32'h3, 32'h2, 32'h1});
    wait_acc(base + 4, "full_word_accept");
    check("full_word_latency", OW'(out_write), OW'(1));
    wait_idle(100, "full_word_drain");

    // partial word then EoT; in_read low while the EoT word is pending
    base = acc_cnt;
    push_tok(0, 5); push_tok(0, 6); push_tok(1, 32'hDEAD); push_tok(0, 7); push_tok(1, 32'hBEEF);
    exp_q.push_back({1'b0, 4'h3, 32'h0, 32'h0, 32'h6, 32'h5});
    exp_q.push_back({1'b1, 4'h0, 128'h0});
    exp_q.push_back({1'b0, 4'h1, 32'h0, 32'h0, 32'h0, 32'h7});
    exp_q.push_back({1'b1, 4'h0, 128'h0});
    wait_acc(base + 3, "partial_accept");
    check("eot_pend_out_write", OW'(out_write), OW'(1));
    check("eot_pend_in_read", OW'(in_read), OW'(0));
    wait_idle(100, "partial_drain");

    // aligned EoT: exactly two transfers
    base = xfer_cnt;
    push_tok(0, 1); push_tok(0, 2); push_tok(0, 3); push_tok(0, 4); push_tok(1, 0);
    exp_q.push_back({1'b0, 4'hF, 32'h4, 32'h3, 32'h2, 32'h1});
    exp_q.push_back({1'b1, 4'h0, 128'h0});
    wait_idle(100, "aligned_drain");
    check("aligned_xfers", OW'(xfer_cnt - base), OW'(2));

    // backpressure: loaded word held stable for 10 cycles, no pops
    dn_hold = 1;
    base = acc_cnt;
    for (int i = 0; i < 8; i++) push_tok(0, 32'h10 + i);
    exp_q.push_back({1'b0, 4'hF, 32'h13, 32'h12, 32'h11, 32'h10});
    exp_q.push_back({1'b0, 4'hF, 32'h17, 32'h16, 32'h15, 32'h14});
    wait_acc(base + 4, "bp_accept");
    held = out_din;
    check("bp_loaded", OW'(out_write), OW'(1));
    good = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (out_din === held && out_write === 1'b1 && in_read === 1'b0) good++;
    end
    check("bp_hold_cycles", OW'(good), OW'(10));
    check("bp_no_pop", OW'(acc_cnt - base), OW'(4));
    dn_hold = 0;
    wait_idle(100, "bp_drain");

    // throughput: 64 back-to-back tokens
    base = xfer_cnt;
    for (int i = 0; i < 64; i++) send(0, 32'h100 + i);
    @(negedge clk);
    good = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); #1;
      if (acc_s === 1'b1) good++;
    end
    check("throughput_read_cycles", OW'(good), OW'(64));
    wait_idle(100, "throughput_drain");
    check("throughput_words", OW'(xfer_cnt - base), OW'(16));

    // random gaps and backpressure
    up_rand = 1;
    dn_rand = 1;
    for (int i = 0; i < 10000; i++) send($urandom_range(0, 15) == 0, $urandom);
    send(1, 0);
    wait_idle(80000, "random_drain");
    up_rand = 0;
    dn_rand = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
